// File: rtl/uart_pkg.sv
// Shared UART constants: default RX FIFO depth, register offsets and
// status register bit positions used by the register interface.
package uart_pkg;

    localparam int unsigned UART_RX_FIFO_DEPTH = 16;

    localparam logic [7:0] UART_CTRL_OFS   = 8'h00;
    localparam logic [7:0] UART_STATUS_OFS = 8'h04;
    localparam logic [7:0] UART_RXDATA_OFS = 8'h08;
    localparam logic [7:0] UART_TXDATA_OFS = 8'h0C;

    localparam int unsigned UART_STAT_EMPTY_BIT = 0;
    localparam int unsigned UART_STAT_FULL_BIT  = 1;
    localparam int unsigned UART_STAT_OVF_BIT   = 2;
    localparam int unsigned UART_STAT_LEVEL_BIT = 3;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// DEPTH x DW storage: synchronous write, asynchronous read, no reset.
// Shared between the RX and TX FIFOs.
module uart_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DW-1:0]            rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Write port: store one entry per enabled cycle
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with sticky overflow and status decode.
// Optional macro UART_RX_FIFO_LEVEL_EN enables the registered level_o output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int unsigned DW     = 8,
    parameter int unsigned THRESH = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [DW-1:0]            rx_din_i,
    input  logic                     rx_done_tick_i,
    input  logic                     rd_en_i,
    input  logic                     flush_i,
    input  logic                     ovf_clr_i,
    output logic [DW-1:0]            dout_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o,
    output logic                     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    // Elaboration-time guard on parameter legality
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (THRESH < 1) || (THRESH > DEPTH)) begin : g_param_check
        $error("uart_rx_fifo: illegal DEPTH/THRESH");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          empty_s, full_s, push_s, pop_s, ovf_set_s, we_s;
    logic [DW-1:0] rdata_s;

    assign empty_s = (count_q == {(AW+1){1'b0}});
    assign full_s  = (count_q == DEPTH_C);

    // Accept/drop decisions and next-state for pointers, count and overflow
    always_comb begin
        pop_s     = rd_en_i & ~empty_s;
        push_s    = rx_done_tick_i & (~full_s | pop_s);
        ovf_set_s = rx_done_tick_i & full_s & ~pop_s & ~flush_i;
        we_s      = push_s & ~flush_i & rstn_i;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;

        if (flush_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end
        end

        // A new overflow outranks a clear in the same cycle
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (rx_din_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

`ifdef UART_RX_FIFO_LEVEL_EN
    localparam logic [AW:0] THRESH_C = (AW+1)'(THRESH);
    logic level_q, level_d;

    assign level_d = (count_d >= THRESH_C);

    // Level flag tracks next count so it lines up with count_o
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
`else
    assign level_o = 1'b0;
`endif

    assign empty_o = empty_s;
    assign full_o  = full_s;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign dout_o  = empty_s ? {DW{1'b0}} : rdata_s;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, DW=8, THRESH=8).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rstn_i = 1'b0;
    logic [7:0] rx_din_i = 8'h00;
    logic       rx_done_tick_i = 1'b0;
    logic       rd_en_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       ovf_clr_i = 1'b0;
    logic [7:0] dout_o;
    logic       empty_o, full_o, ovf_o, level_o;
    logic [4:0] count_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    uart_rx_fifo #(.DEPTH(16), .DW(8), .THRESH(8)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn_i),
        .rx_din_i       (rx_din_i),
        .rx_done_tick_i (rx_done_tick_i),
        .rd_en_i        (rd_en_i),
        .flush_i        (flush_i),
        .ovf_clr_i      (ovf_clr_i),
        .dout_o         (dout_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .count_o        (count_o),
        .ovf_o          (ovf_o),
        .level_o        (level_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_din_i = b;
        rx_done_tick_i = 1'b1;
        step();
        rx_done_tick_i = 1'b0;
    endtask

    task automatic pop();
        rd_en_i = 1'b1;
        step();
        rd_en_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        step();
        step();
        rstn_i = 1'b1;
        step();
        chk_cnt++; if (empty_o !== 1'b1) $display("FAIL reset_empty: got %0b want 1", empty_o); else pass_cnt++;
        chk_cnt++; if (count_o !== 5'd0) $display("FAIL reset_count: got %0d want 0", count_o); else pass_cnt++;
        chk_cnt++; if (dout_o !== 8'h00) $display("FAIL reset_dout: got %02h want 00", dout_o); else pass_cnt++;
        chk_cnt++; if (ovf_o !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", ovf_o); else pass_cnt++;
        chk_cnt++; if (full_o !== 1'b0) $display("FAIL reset_full: got %0b want 0", full_o); else pass_cnt++;
        chk_cnt++; if (level_o !== 1'b0) $display("FAIL reset_level: got %0b want 0", level_o); else pass_cnt++;
    endtask

    task automatic test_order();
        logic [7:0] exp [3];
        exp[0] = 8'hA4; exp[1] = 8'h5B; exp[2] = 8'hC3;
        for (int i = 0; i < 3; i++) push(exp[i]);
        chk_cnt++; if (count_o !== 5'd3) $display("FAIL order_count: got %0d want 3", count_o); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            rd_en_i = 1'b1;
            #1;
            chk_cnt++; if (dout_o !== exp[i]) $display("FAIL order_pop%0d: got %02h want %02h", i, dout_o, exp[i]); else pass_cnt++;
            step();
            rd_en_i = 1'b0;
        end
        chk_cnt++; if (empty_o !== 1'b1) $display("FAIL order_empty: got %0b want 1", empty_o); else pass_cnt++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) push(8'(i));
        chk_cnt++; if (full_o !== 1'b1) $display("FAIL ovf_full: got %0b want 1", full_o); else pass_cnt++;
        chk_cnt++; if (count_o !== 5'd16) $display("FAIL ovf_count: got %0d want 16", count_o); else pass_cnt++;
        chk_cnt++; if (ovf_o !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", ovf_o); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            chk_cnt++; if (dout_o !== 8'(i)) $display("FAIL ovf_pop%0d: got %02h want %02h", i, dout_o, 8'(i)); else pass_cnt++;
            pop();
        end
        chk_cnt++; if (empty_o !== 1'b1) $display("FAIL ovf_drained: got %0b want 1", empty_o); else pass_cnt++;
        ovf_clr_i = 1'b1;
        step();
        ovf_clr_i = 1'b0;
        chk_cnt++; if (ovf_o !== 1'b0) $display("FAIL ovf_clear: got %0b want 0", ovf_o); else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        rx_din_i = 8'h77;
        rx_done_tick_i = 1'b1;
        rd_en_i = 1'b1;
        #1;
        chk_cnt++; if (dout_o !== 8'h20) $display("FAIL fullpp_head: got %02h want 20", dout_o); else pass_cnt++;
        step();
        rx_done_tick_i = 1'b0;
        rd_en_i = 1'b0;
        chk_cnt++; if (count_o !== 5'd16) $display("FAIL fullpp_count: got %0d want 16", count_o); else pass_cnt++;
        chk_cnt++; if (ovf_o !== 1'b0) $display("FAIL fullpp_ovf: got %0b want 0", ovf_o); else pass_cnt++;
        for (int i = 1; i < 16; i++) begin
            chk_cnt++; if (dout_o !== 8'h20 + 8'(i)) $display("FAIL fullpp_pop%0d: got %02h want %02h", i, dout_o, 8'h20 + 8'(i)); else pass_cnt++;
            pop();
        end
        chk_cnt++; if (dout_o !== 8'h77) $display("FAIL fullpp_last: got %02h want 77", dout_o); else pass_cnt++;
        pop();
        chk_cnt++; if (empty_o !== 1'b1) $display("FAIL fullpp_empty: got %0b want 1", empty_o); else pass_cnt++;
    endtask

    task automatic test_empty_push_pop();
        rx_din_i = 8'h3C;
        rx_done_tick_i = 1'b1;
        rd_en_i = 1'b1;
        step();
        rx_done_tick_i = 1'b0;
        rd_en_i = 1'b0;
        chk_cnt++; if (count_o !== 5'd1) $display("FAIL emptypp_count: got %0d want 1", count_o); else pass_cnt++;
        chk_cnt++; if (dout_o !== 8'h3C) $display("FAIL emptypp_dout: got %02h want 3C", dout_o); else pass_cnt++;
        pop();
        pop();
        chk_cnt++; if (count_o !== 5'd0) $display("FAIL pop_when_empty: got %0d want 0", count_o); else pass_cnt++;
        chk_cnt++; if (dout_o !== 8'h00) $display("FAIL pop_empty_dout: got %02h want 00", dout_o); else pass_cnt++;
    endtask

    task automatic test_ovf_clr_and_flush();
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        rx_din_i = 8'hEE;
        rx_done_tick_i = 1'b1;
        ovf_clr_i = 1'b1;
        step();
        rx_done_tick_i = 1'b0;
        ovf_clr_i = 1'b0;
        chk_cnt++; if (ovf_o !== 1'b1) $display("FAIL ovfclr_set_wins: got %0b want 1", ovf_o); else pass_cnt++;
        chk_cnt++; if (dout_o !== 8'h40) $display("FAIL ovfclr_head: got %02h want 40", dout_o); else pass_cnt++;
        rx_din_i = 8'h99;
        rx_done_tick_i = 1'b1;
        flush_i = 1'b1;
        step();
        rx_done_tick_i = 1'b0;
        flush_i = 1'b0;
        chk_cnt++; if (count_o !== 5'd0) $display("FAIL flush_count: got %0d want 0", count_o); else pass_cnt++;
        chk_cnt++; if (empty_o !== 1'b1) $display("FAIL flush_empty: got %0b want 1", empty_o); else pass_cnt++;
        chk_cnt++; if (ovf_o !== 1'b1) $display("FAIL flush_ovf_kept: got %0b want 1", ovf_o); else pass_cnt++;
        push(8'h5A);
        chk_cnt++; if (dout_o !== 8'h5A) $display("FAIL flush_after_push: got %02h want 5A", dout_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        push(8'h44);
        rstn_i = 1'b0;
        rx_din_i = 8'h66;
        rx_done_tick_i = 1'b1;
        rd_en_i = 1'b1;
        step();
        rx_done_tick_i = 1'b0;
        rd_en_i = 1'b0;
        rstn_i = 1'b1;
        chk_cnt++; if (count_o !== 5'd0) $display("FAIL midrst_count: got %0d want 0", count_o); else pass_cnt++;
        chk_cnt++; if (ovf_o !== 1'b0) $display("FAIL midrst_ovf: got %0b want 0", ovf_o); else pass_cnt++;
        chk_cnt++; if (dout_o !== 8'h00) $display("FAIL midrst_dout: got %02h want 00", dout_o); else pass_cnt++;
    endtask

    task automatic test_level();
        for (int i = 0; i < 7; i++) push(8'h80 + 8'(i));
        chk_cnt++; if (level_o !== 1'b0) $display("FAIL level_at7: got %0b want 0", level_o); else pass_cnt++;
        push(8'h87);
`ifdef UART_RX_FIFO_LEVEL_EN
        chk_cnt++; if (level_o !== 1'b1) $display("FAIL level_at8: got %0b want 1", level_o); else pass_cnt++;
`else
        chk_cnt++; if (level_o !== 1'b0) $display("FAIL level_tied: got %0b want 0", level_o); else pass_cnt++;
`endif
        chk_cnt++; if (count_o !== 5'd8) $display("FAIL level_count8: got %0d want 8", count_o); else pass_cnt++;
        pop();
        chk_cnt++; if (level_o !== 1'b0) $display("FAIL level_after_pop: got %0b want 0", level_o); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_order();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_ovf_clr_and_flush();
        test_reset_mid();
        test_level();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_uart_rx_fifo
